// File: rtl/cache_mem_resp.sv
// Memory-side responder for the cache controller: serves wrapping, critical-word-first
// fill bursts and writeback bursts from a word-addressed array with a configurable read latency.
module cache_mem_resp #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BEATS   = 4,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_last,
    output logic          resp_wack
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a raised valid
    // stays up with its payload unchanged until that edge, and ready never depends on valid.

    localparam int BW = $clog2(BEATS);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, WACK} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] k, k_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] addr_q, addr_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;
    logic          wr_en;
    logic          unused_addr_hi;

    // Address bits above the array index alias onto the same words.
    assign unused_addr_hi = ^req_addr[AW-1:IW];

    // Beat k of a line wraps within the BEATS-aligned line around the critical word.
    function automatic logic [IW-1:0] beat_idx(input logic [IW-1:0] a, input logic [BW-1:0] beat);
        logic [BW-1:0] off;
        off = a[BW-1:0] + beat;
        return {a[IW-1:BW], off};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt = req_addr[IW-1:0];
                    k_nxt    = '0;
                    if (req_we) begin
                        state_nxt = WBURST;
                    end else if (LATENCY == 0) begin
                        state_nxt = RBURST;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = RBURST;
            end
            RBURST: begin
                if (resp_ready) begin
                    k_nxt = k + BW'(1);
                    if (k == LAST_BEAT) state_nxt = IDLE;
                end
            end
            WBURST: begin
                if (wdata_valid) begin
                    k_nxt = k + BW'(1);
                    if (k == LAST_BEAT) state_nxt = WACK;
                end
            end
            WACK: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The read port is addressed with next-cycle beat so registered data lines up with resp_valid.
    assign wr_en = (state == WBURST) && wdata_valid && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) mem[beat_idx(addr_q, k)] <= wdata;
        rd_q <= mem[beat_idx(addr_nxt, k_nxt)];
    end

    always_comb begin
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        resp_last   = 1'b0;
        resp_wack   = 1'b0;
        case (state)
            IDLE:   req_ready = 1'b1;
            RBURST: begin
                resp_valid = 1'b1;
                resp_data  = rd_q;
                resp_last  = (k == LAST_BEAT);
            end
            WBURST: wdata_ready = 1'b1;
            WACK: begin
                resp_valid = 1'b1;
                resp_wack  = 1'b1;
                resp_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
